// File: rtl/nibbler_fetch_unit.sv
// nibbler_fetch_unit: fetch stage for the Nibbler 4-bit CPU.
// Owns the 12-bit PC, addresses the combinational program ROM, latches one
// or two instruction bytes and presents decoded fields to control.
// Optional feature macro: PC_WRAP_FLAG_EN adds a sticky pc_wrap output.
//
// Handshake: en is the single advance qualifier. Every register update
// happens on a rising clk edge with en=1; with en=0 everything holds.
// instr_valid is high in EXEC only while en=1, so control sees exactly one
// en-qualified cycle per instruction and may consume it on that edge.
module nibbler_fetch_unit #(
   parameter logic [11:0] RESET_VECTOR = 12'h000,
   parameter logic [15:0] LONG_OP_MASK = 16'h000F
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [7:0]  rom_data,
   input  logic        branch_take,
   output logic [11:0] pc_addr,
   output logic [3:0]  opcode,
   output logic [3:0]  operand,
   output logic [11:0] jump_addr,
   output logic        instr_valid,
   output logic        is_long,
`ifdef PC_WRAP_FLAG_EN
   output logic        pc_wrap,
`endif
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      FETCH1 = 2'd0,
      FETCH2 = 2'd1,
      EXEC   = 2'd2
   } state_t;

   state_t      r_state;
   logic [11:0] r_pc;
   logic [7:0]  r_instr;
   logic [7:0]  r_low_byte;
   logic        r_is_long;

   state_t      w_next_state;
   logic [11:0] w_next_pc;
   logic [11:0] w_pc_inc;
   logic        w_wrap_inc;
   logic [11:0] w_jump_addr;

   // Long-ness is captured with the opcode byte so a cleared instruction
   // register (opcode 0) never reports itself as a 2-byte instruction.
   assign w_pc_inc    = r_pc + 12'd1;
   assign w_jump_addr = r_is_long ? {r_instr[3:0], r_low_byte} : 12'h000;

   // Next-state and next-PC selection; defaults hold the current values.
   always_comb begin
      w_next_state = r_state;
      w_next_pc    = r_pc;
      w_wrap_inc   = 1'b0;
      case (r_state)
         FETCH1: begin
            w_next_pc    = w_pc_inc;
            w_wrap_inc   = (r_pc == 12'hFFF);
            w_next_state = LONG_OP_MASK[rom_data[7:4]] ? FETCH2 : EXEC;
         end
         FETCH2: begin
            w_next_pc    = w_pc_inc;
            w_wrap_inc   = (r_pc == 12'hFFF);
            w_next_state = EXEC;
         end
         EXEC: begin
            if (r_is_long && branch_take) begin
               w_next_pc = w_jump_addr;
            end
            w_next_state = FETCH1;
         end
         default: begin
            w_next_state = FETCH1;
         end
      endcase
   end

   // State, PC and instruction byte registers; frozen while en is low.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= FETCH1;
         r_pc       <= RESET_VECTOR;
         r_instr    <= 8'h00;
         r_low_byte <= 8'h00;
         r_is_long  <= 1'b0;
      end else if (en) begin
         r_state <= w_next_state;
         r_pc    <= w_next_pc;
         if (r_state == FETCH1) begin
            r_instr   <= rom_data;
            r_is_long <= LONG_OP_MASK[rom_data[7:4]];
         end
         if (r_state == FETCH2) begin
            r_low_byte <= rom_data;
         end
      end
   end

`ifdef PC_WRAP_FLAG_EN
   logic r_pc_wrap;

   // Sticky flag: set only by sequential increment past 12'hFFF, never by a branch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc_wrap <= 1'b0;
      end else if (en && w_wrap_inc) begin
         r_pc_wrap <= 1'b1;
      end
   end

   assign pc_wrap = r_pc_wrap;
`else
   logic w_unused_wrap;
   assign w_unused_wrap = w_wrap_inc;
`endif

   assign pc_addr     = r_pc;
   assign opcode      = r_instr[7:4];
   assign operand     = r_instr[3:0];
   assign jump_addr   = w_jump_addr;
   assign is_long     = r_is_long;
   assign instr_valid = (r_state == EXEC) && en;
   assign dbg_state   = r_state;

endmodule
